// File: rtl/issue_splitter.sv
// Decode-stage issue register for the dual-issue pipeline. When slot 2 depends on
// slot 1 the pair is split: slot 1 issues alone, then old slot 2 re-issues in slot 1.
module issue_splitter #(
    parameter logic [31:0] NOP   = 32'h0000_0000,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             dependency,
    input  logic [31:0]      instrF1,
    input  logic [31:0]      instrF2,
    input  logic [31:0]      PCPlus4F,
    output logic [31:0]      instrD1,
    output logic [31:0]      instrD2,
    output logic [31:0]      PCPlus4D1,
    output logic [31:0]      PCPlus4D2,
    output logic             validD1,
    output logic             validD2,
    output logic             killD2,
    output logic             stallF,
    output logic             splitting,
    output logic [CNT_W-1:0] splitcount
);

    typedef enum logic {PAIR, SPLIT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
    } slot_t;

    state_t           state, stateNext;
    slot_t            slot1, slot1Next, slot2, slot2Next;
    logic [31:0]      pc1, pc1Next;
    logic [CNT_W-1:0] cnt, cntNext;

    // Slot 2 always sits one word after slot 1, so only slot 1's PC+4 is stored.
    assign PCPlus4D1  = pc1;
    assign PCPlus4D2  = pc1 + 32'd4;
    assign instrD1    = slot1.instr;
    assign instrD2    = slot2.instr;
    assign validD1    = slot1.valid;
    assign validD2    = slot2.valid;
    assign splitting  = (state == SPLIT);
    assign killD2     = (state == PAIR) & slot2.valid & dependency;
    assign stallF     = killD2 & ~flushD;
    assign splitcount = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PAIR;
            slot1 <= '{instr: NOP, valid: 1'b0};
            slot2 <= '{instr: NOP, valid: 1'b0};
            pc1   <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            slot1 <= slot1Next;
            slot2 <= slot2Next;
            pc1   <= pc1Next;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        slot1Next = slot1;
        slot2Next = slot2;
        pc1Next   = pc1;
        cntNext   = cnt;
        if (flushD) begin
            // Flush drops any pending split half along with the pair.
            stateNext = PAIR;
            slot1Next = '{instr: NOP, valid: 1'b0};
            slot2Next = '{instr: NOP, valid: 1'b0};
        end else if (!stallD) begin
            if (killD2) begin
                stateNext = SPLIT;
                slot1Next = '{instr: slot2.instr, valid: 1'b1};
                slot2Next = '{instr: NOP, valid: 1'b0};
                pc1Next   = PCPlus4D2;
                if (cnt != {CNT_W{1'b1}})
                    cntNext = cnt + 1'b1;
            end else begin
                // Fetch was held during the split cycle, so the pair at F is still the next one.
                stateNext = PAIR;
                slot1Next = '{instr: instrF1, valid: 1'b1};
                slot2Next = '{instr: instrF2, valid: 1'b1};
                pc1Next   = PCPlus4F;
            end
        end
    end

endmodule

// File: tb/tb_issue_splitter.sv
// Directed bench for issue_splitter: pair issue, RAW/WAW splits, stall, flush, reset,
// and counter saturation on a narrow-counter instance.
module tb_issue_splitter;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ADD1  = 32'h0043_0820; // add $1,$2,$3
    localparam logic [31:0] ADD2  = 32'h00A6_2020; // add $4,$5,$6
    localparam logic [31:0] SUB   = 32'h0025_2022; // sub $4,$1,$5
    localparam logic [31:0] LW    = 32'h8D07_0000; // lw $7,0($8)
    localparam logic [31:0] ADDI  = 32'h20E7_0001; // addi $7,$7,1

    logic        clk = 1'b0;
    logic        rst, stallD, flushD, dependency;
    logic [31:0] instrF1, instrF2, PCPlus4F;
    logic [31:0] instrD1, instrD2, PCPlus4D1, PCPlus4D2;
    logic        validD1, validD2, killD2, stallF, splitting;
    logic [15:0] splitcount;

    logic [31:0] instrD1b, instrD2b, PCPlus4D1b, PCPlus4D2b;
    logic        validD1b, validD2b, killD2b, stallFb, splittingb;
    logic [1:0]  splitcountb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    issue_splitter #(.NOP(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .dependency(dependency),
        .instrF1(instrF1), .instrF2(instrF2), .PCPlus4F(PCPlus4F),
        .instrD1(instrD1), .instrD2(instrD2), .PCPlus4D1(PCPlus4D1), .PCPlus4D2(PCPlus4D2),
        .validD1(validD1), .validD2(validD2), .killD2(killD2), .stallF(stallF),
        .splitting(splitting), .splitcount(splitcount)
    );

    issue_splitter #(.NOP(NOP), .CNT_W(2)) dutNarrow (
        .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .dependency(dependency),
        .instrF1(instrF1), .instrF2(instrF2), .PCPlus4F(PCPlus4F),
        .instrD1(instrD1b), .instrD2(instrD2b), .PCPlus4D1(PCPlus4D1b), .PCPlus4D2(PCPlus4D2b),
        .validD1(validD1b), .validD2(validD2b), .killD2(killD2b), .stallF(stallFb),
        .splitting(splittingb), .splitcount(splitcountb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc);
        instrF1  = i1;
        instrF2  = i2;
        PCPlus4F = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; stallD = 1'b0; flushD = 1'b0; dependency = 1'b1;
        drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0F00);
        step(); step();
        total++; if (instrD1 !== NOP || instrD2 !== NOP) begin bad++;
            $display("FAIL reset_instr got=%h/%h exp=%h/%h", instrD1, instrD2, NOP, NOP); end
        total++; if (PCPlus4D1 !== 32'd0 || PCPlus4D2 !== 32'd4) begin bad++;
            $display("FAIL reset_pc got=%h/%h exp=0/4", PCPlus4D1, PCPlus4D2); end
        total++; if ({validD1, validD2, splitting} !== 3'b000 || splitcount !== 16'd0) begin bad++;
            $display("FAIL reset_state got v=%b%b s=%b c=%0d exp v=00 s=0 c=0", validD1, validD2, splitting, splitcount); end
        // validD2=0 in PAIR must not split even with dependency high
        total++; if (killD2 !== 1'b0 || stallF !== 1'b0) begin bad++;
            $display("FAIL reset_nokill got kill=%b stallF=%b exp 0/0", killD2, stallF); end
        rst = 1'b0;
        step();
        total++; if (instrD1 !== 32'hDEAD_BEEF || splitting !== 1'b0 || splitcount !== 16'd0) begin bad++;
            $display("FAIL invalid_nosplit got i1=%h s=%b c=%0d exp i1=deadbeef s=0 c=0", instrD1, splitting, splitcount); end
        dependency = 1'b0;
    endtask

    task automatic test_independent();
        drive(ADD1, ADD2, 32'h0000_0104);
        step();
        total++; if (instrD1 !== ADD1 || instrD2 !== ADD2) begin bad++;
            $display("FAIL indep_instr got=%h/%h exp=%h/%h", instrD1, instrD2, ADD1, ADD2); end
        total++; if (PCPlus4D1 !== 32'h104 || PCPlus4D2 !== 32'h108) begin bad++;
            $display("FAIL indep_pc got=%h/%h exp=104/108", PCPlus4D1, PCPlus4D2); end
        total++; if ({validD1, validD2, killD2, stallF} !== 4'b1100) begin bad++;
            $display("FAIL indep_ctl got=%b exp=1100", {validD1, validD2, killD2, stallF}); end
        drive(32'h1111_1111, 32'h2222_2222, 32'h0000_010C);
        step();
        total++; if (instrD1 !== 32'h1111_1111 || instrD2 !== 32'h2222_2222 || PCPlus4D1 !== 32'h10C) begin bad++;
            $display("FAIL indep_next got=%h/%h pc=%h exp=11111111/22222222 pc=10c", instrD1, instrD2, PCPlus4D1); end
    endtask

    task automatic test_raw_split();
        drive(ADD1, SUB, 32'h0000_0200);
        step();
        dependency = 1'b1;
        drive(32'h3333_3333, 32'h4444_4444, 32'h0000_0208);
        #1;
        total++; if ({killD2, stallF, splitting} !== 3'b110) begin bad++;
            $display("FAIL raw_kill got kill/stallF/split=%b exp=110", {killD2, stallF, splitting}); end
        step();
        total++; if (instrD1 !== SUB || instrD2 !== NOP || PCPlus4D1 !== 32'h204) begin bad++;
            $display("FAIL raw_reissue got=%h/%h pc=%h exp=%h/%h pc=204", instrD1, instrD2, PCPlus4D1, SUB, NOP); end
        total++; if ({validD1, validD2, splitting} !== 3'b101 || splitcount !== 16'd1) begin bad++;
            $display("FAIL raw_state got v=%b%b s=%b c=%0d exp v=10 s=1 c=1", validD1, validD2, splitting, splitcount); end
        // dependency is ignored in SPLIT
        total++; if (killD2 !== 1'b0 || stallF !== 1'b0) begin bad++;
            $display("FAIL raw_splitignore got kill=%b stallF=%b exp 0/0", killD2, stallF); end
        step();
        total++; if (instrD1 !== 32'h3333_3333 || instrD2 !== 32'h4444_4444 || splitting !== 1'b0 || validD2 !== 1'b1) begin bad++;
            $display("FAIL raw_resume got=%h/%h s=%b v2=%b exp=33333333/44444444 s=0 v2=1", instrD1, instrD2, splitting, validD2); end
        dependency = 1'b0;
    endtask

    task automatic test_waw_split();
        drive(LW, ADDI, 32'h0000_0300);
        step();
        dependency = 1'b1;
        #1;
        total++; if ({killD2, stallF} !== 2'b11) begin bad++;
            $display("FAIL waw_kill got=%b exp=11", {killD2, stallF}); end
        step();
        dependency = 1'b0;
        total++; if (instrD1 !== ADDI || instrD2 !== NOP || PCPlus4D1 !== 32'h304 || splitcount !== 16'd2) begin bad++;
            $display("FAIL waw_reissue got=%h/%h pc=%h c=%0d exp=%h/%h pc=304 c=2", instrD1, instrD2, PCPlus4D1, splitcount, ADDI, NOP); end
        drive(32'h5555_5555, 32'h6666_6666, 32'h0000_0400);
        step();
        total++; if (instrD1 !== 32'h5555_5555 || splitting !== 1'b0) begin bad++;
            $display("FAIL waw_resume got=%h s=%b exp=55555555 s=0", instrD1, splitting); end
    endtask

    task automatic test_stall_split();
        dependency = 1'b1;
        stallD = 1'b1;
        drive(32'h7777_7777, 32'h8888_8888, 32'h0000_0500);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (instrD1 !== 32'h5555_5555 || instrD2 !== 32'h6666_6666 || PCPlus4D1 !== 32'h400) begin bad++;
                $display("FAIL stall_hold%0d got=%h/%h pc=%h exp=55555555/66666666 pc=400", i, instrD1, instrD2, PCPlus4D1); end
            total++; if ({killD2, stallF, splitting} !== 3'b110 || splitcount !== 16'd2) begin bad++;
                $display("FAIL stall_kill%0d got=%b c=%0d exp=110 c=2", i, {killD2, stallF, splitting}, splitcount); end
        end
        stallD = 1'b0;
        step();
        total++; if (instrD1 !== 32'h6666_6666 || PCPlus4D1 !== 32'h404 || splitting !== 1'b1 || splitcount !== 16'd3) begin bad++;
            $display("FAIL stall_release got=%h pc=%h s=%b c=%0d exp=66666666 pc=404 s=1 c=3", instrD1, PCPlus4D1, splitting, splitcount); end
    endtask

    task automatic test_flush_reset();
        dependency = 1'b0;
        flushD = 1'b1;
        step();
        flushD = 1'b0;
        total++; if (instrD1 !== NOP || instrD2 !== NOP || {validD1, validD2} !== 2'b00) begin bad++;
            $display("FAIL flush_slots got=%h/%h v=%b%b exp=%h/%h v=00", instrD1, instrD2, validD1, validD2, NOP, NOP); end
        total++; if (splitting !== 1'b0 || stallF !== 1'b0 || splitcount !== 16'd3) begin bad++;
            $display("FAIL flush_state got s=%b stallF=%b c=%0d exp 0/0/3", splitting, stallF, splitcount); end
        drive(ADD1, SUB, 32'h0000_0600);
        step();
        dependency = 1'b1;
        flushD = 1'b1;
        #1;
        total++; if (killD2 !== 1'b1 || stallF !== 1'b0) begin bad++;
            $display("FAIL flush_masks_stall got kill=%b stallF=%b exp 1/0", killD2, stallF); end
        step();
        flushD = 1'b0;
        total++; if (splitting !== 1'b0 || validD1 !== 1'b0 || splitcount !== 16'd3) begin bad++;
            $display("FAIL flush_beats_split got s=%b v1=%b c=%0d exp 0/0/3", splitting, validD1, splitcount); end
        dependency = 1'b0;
        step();
        dependency = 1'b1;
        step();
        total++; if (splitting !== 1'b1 || splitcount !== 16'd4) begin bad++;
            $display("FAIL presplit got s=%b c=%0d exp 1/4", splitting, splitcount); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        dependency = 1'b0;
        total++; if (instrD1 !== NOP || instrD2 !== NOP || PCPlus4D1 !== 32'd0 || {validD1, validD2, splitting} !== 3'b000 || splitcount !== 16'd0) begin bad++;
            $display("FAIL midsplit_reset got=%h/%h pc=%h v=%b%b s=%b c=%0d exp all reset", instrD1, instrD2, PCPlus4D1, validD1, validD2, splitting, splitcount); end
    endtask

    task automatic test_saturation();
        logic [1:0] expCnt [5];
        expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(ADD1, SUB, 32'h0000_0700);
        step();
        for (int i = 0; i < 5; i++) begin
            dependency = 1'b1;
            step();
            total++; if (splittingb !== 1'b1 || splitcountb !== expCnt[i]) begin bad++;
                $display("FAIL sat_cnt%0d got s=%b c=%0d exp s=1 c=%0d", i, splittingb, splitcountb, expCnt[i]); end
            dependency = 1'b0;
            step();
        end
        total++; if (splitcount !== 16'd5) begin bad++;
            $display("FAIL wide_cnt got=%0d exp=5", splitcount); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_split();
        test_waw_split();
        test_stall_split();
        test_flush_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
